// File: rtl/reg_file_ba.sv
// General-purpose register file: one write port, two combinational read ports, and a
// busy scoreboard per register. Port A can mask R0 to zero for base-address use.
module reg_file_ba #(
    parameter int WIDTH        = 32,
    parameter int NUM_REGS     = 16,
    parameter int ADDR_W       = 4,
    parameter bit BYPASS       = 1'b1,
    parameter bit R0_HARDWIRED = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic              BAout,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy_a,
    output logic              busy_b
);

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [WIDTH-1:0]    arr_a;
    logic [WIDTH-1:0]    arr_b;
    logic                bsy_a;
    logic                bsy_b;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {{(32-ADDR_W){1'b0}}, a} < 32'(NUM_REGS);
    endfunction

    // Write clears busy, reserve sets it; evaluated in that order so a same-address
    // reservation survives the completing write.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!(R0_HARDWIRED && i == 0)) begin
                if (wr_en && wr_addr == ADDR_W'(i)) begin
                    regs_d[i] = wr_data;
                    busy_d[i] = 1'b0;
                end
                if (rsv_en && rsv_addr == ADDR_W'(i)) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Array lookup by decode so out-of-range addresses naturally yield zero.
    always_comb begin
        arr_a = '0;
        arr_b = '0;
        bsy_a = 1'b0;
        bsy_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                arr_a = regs_q[i];
                bsy_a = busy_q[i];
            end
            if (rd_addr_b == ADDR_W'(i)) begin
                arr_b = regs_q[i];
                bsy_b = busy_q[i];
            end
        end
    end

    // Later assignments take priority: range check, then R0 masks, then bypass.
    always_comb begin
        rd_data_a = arr_a;
        if (BYPASS && wr_en && !clr && wr_addr == rd_addr_a) rd_data_a = wr_data;
        if (R0_HARDWIRED && rd_addr_a == '0)                rd_data_a = '0;
        if (BAout && rd_addr_a == '0)                       rd_data_a = '0;
        if (!in_range(rd_addr_a))                           rd_data_a = '0;

        rd_data_b = arr_b;
        if (BYPASS && wr_en && !clr && wr_addr == rd_addr_b) rd_data_b = wr_data;
        if (R0_HARDWIRED && rd_addr_b == '0)                rd_data_b = '0;
        if (!in_range(rd_addr_b))                           rd_data_b = '0;
    end

    assign busy_a = bsy_a;
    assign busy_b = bsy_b;

endmodule
